mem_arbiter: RTL and testbench

- Shares one single-port memory (OBI-style request/grant/rvalid) between instruction fetch (port 0, IF) and the load/store unit (port 1, LS).
- Sits between the fetch stage, the LSU and the unified memory. Used when the core moves to a shared-memory, multi-cycle configuration.
- Arbitrates requests, holds the selected request stable until granted, tracks outstanding transactions in order, and routes responses back to their owner.
- Includes a starvation guard so fetch always makes progress under LSU-heavy traffic.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port OBI-style arbiter: instruction fetch (IF) and load/store unit (LS)
// share one single-port memory. Outstanding transactions are tracked in an
// in-order owner FIFO so that responses go back to the port that issued them.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [3:0]        ls_be_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
  localparam int unsigned StvW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLockIf, StLockLs} state_e;

  state_e              state_q, state_d;
  logic [MAX_OUTST-1:0] owner_q;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q;
  logic [StvW-1:0]     starve_q;
  logic                err_q;

  logic sel_ls, sel_req, full, empty, push, pop, stray, lock_drop, head;

  assign full  = (count_q == CntW'(MAX_OUTST));
  assign empty = (count_q == '0);
  assign head  = owner_q[rptr_q];

  // Port selection, request gating and memory-side mux
  always_comb begin
    unique case (state_q)
      StLockIf: sel_ls = 1'b0;
      StLockLs: sel_ls = 1'b1;
      default:  sel_ls = ls_req_i &&
                         !(if_req_i && (starve_q == StvW'(STARVE_MAX)));
    endcase
    sel_req     = sel_ls ? ls_req_i : if_req_i;
    mem_req_o   = sel_req && !full && rst_ni;
    mem_we_o    = sel_ls ? ls_we_i    : 1'b0;
    mem_addr_o  = sel_ls ? ls_addr_i  : if_addr_i;
    mem_wdata_o = sel_ls ? ls_wdata_i : '0;
    mem_be_o    = sel_ls ? ls_be_i    : 4'hF;
    ls_gnt_o    = mem_req_o && mem_gnt_i && sel_ls;
    if_gnt_o    = mem_req_o && mem_gnt_i && !sel_ls;
    // Locked port withdrew its request before being granted
    lock_drop   = (state_q != StIdle) && !sel_req;
  end

  // Lock next-state: hold the selected port until it is granted
  always_comb begin
    state_d = state_q;
    if (mem_req_o && !mem_gnt_i) begin
      state_d = sel_ls ? StLockLs : StLockIf;
    end else if (mem_req_o && mem_gnt_i) begin
      state_d = StIdle;
    end else if (lock_drop) begin
      state_d = StIdle;
    end
  end

  // Lock state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Response routing by FIFO head, zero latency
  always_comb begin
    push        = if_gnt_o || ls_gnt_o;
    pop         = mem_rvalid_i && !empty;
    stray       = mem_rvalid_i && empty;
    if_rvalid_o = pop && !head && rst_ni;
    ls_rvalid_o = pop && head && rst_ni;
    if_rdata_o  = mem_rdata_i;
    ls_rdata_o  = mem_rdata_i;
    err_o       = err_q;
  end

  // Owner FIFO; full is judged on the registered count, so a pop frees a slot next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        owner_q[wptr_q] <= ls_gnt_o;
        wptr_q <= (wptr_q == PtrW'(MAX_OUTST - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrW'(MAX_OUTST - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Starvation counter: consecutive LS grants while IF waits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_q <= '0;
    end else if (ls_gnt_o && (starve_q != StvW'(STARVE_MAX))) begin
      starve_q <= starve_q + StvW'(1);
    end
  end

  // Sticky protocol error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 err_q <= 1'b0;
    else if (stray || lock_drop) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [12:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [12:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [3:0]  ls_be_i;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W(13), .DATA_W(32), .MAX_OUTST(4), .STARVE_MAX(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well away from the edge
  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; ls_req_i = 0; ls_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  logic exp_ls [8];

  initial begin
    rst_ni = 0;
    if_addr_i = 13'h010; ls_addr_i = 13'h100; ls_wdata_i = 32'h55; ls_be_i = 4'h3;
    mem_rdata_i = 0;
    idle_inputs();
    if_req_i = 1; mem_gnt_i = 1;
    #2;
    // Reset: outputs must be quiet even with requests present
    check_eq("rst_mem_req", mem_req_o, 0);
    check_eq("rst_if_gnt", if_gnt_o, 0);
    check_eq("rst_err", err_o, 0);
    idle_inputs();
    next_cycle(); next_cycle();
    rst_ni = 1;
    next_cycle();

    // IF-only read
    if_req_i = 1; if_addr_i = 13'h010; mem_gnt_i = 1; settle();
    check_eq("t1_if_gnt", if_gnt_o, 1);
    check_eq("t1_addr", mem_addr_o, 13'h010);
    check_eq("t1_be", mem_be_o, 4'hF);
    check_eq("t1_we", mem_we_o, 0);
    next_cycle(); idle_inputs();
    next_cycle(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; settle();
    check_eq("t1_if_rvalid", if_rvalid_o, 1);
    check_eq("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);
    check_eq("t1_ls_rvalid", ls_rvalid_o, 0);
    next_cycle(); idle_inputs();

    // LS beats IF
    if_req_i = 1; ls_req_i = 1; ls_we_i = 1; mem_gnt_i = 1; settle();
    check_eq("t2_ls_gnt", ls_gnt_o, 1);
    check_eq("t2_if_gnt", if_gnt_o, 0);
    check_eq("t2_we", mem_we_o, 1);
    check_eq("t2_be", mem_be_o, 4'h3);
    check_eq("t2_addr", mem_addr_o, 13'h100);
    check_eq("t2_wdata", mem_wdata_o, 32'h55);
    next_cycle(); ls_req_i = 0; ls_we_i = 0; settle();
    check_eq("t2_if_gnt2", if_gnt_o, 1);
    check_eq("t2_if_wdata", mem_wdata_o, 0);
    next_cycle(); idle_inputs(); mem_rvalid_i = 1; mem_rdata_i = 32'h1; settle();
    check_eq("t2_rsp1_ls", ls_rvalid_o, 1);
    check_eq("t2_rsp1_if", if_rvalid_o, 0);
    next_cycle(); mem_rdata_i = 32'h2; settle();
    check_eq("t2_rsp2_if", if_rvalid_o, 1);
    check_eq("t2_rsp2_ls", ls_rvalid_o, 0);
    next_cycle(); idle_inputs();

    // Starvation guard: LS,LS,LS,IF repeating
    exp_ls = '{1, 1, 1, 0, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      if_req_i = 1; ls_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = (i != 0);
      settle();
      check_eq($sformatf("t3_ls_gnt%0d", i), ls_gnt_o, exp_ls[i]);
      check_eq($sformatf("t3_if_gnt%0d", i), if_gnt_o, !exp_ls[i]);
      next_cycle();
    end
    idle_inputs(); mem_rvalid_i = 1; settle();
    check_eq("t3_last_if_rsp", if_rvalid_o, 1);
    next_cycle(); idle_inputs();

    // Lock holds IF while LS arrives
    if_req_i = 1; if_addr_i = 13'h020; settle();
    check_eq("t4_addr0", mem_addr_o, 13'h020);
    check_eq("t4_if_gnt0", if_gnt_o, 0);
    for (int i = 1; i < 3; i++) begin
      next_cycle(); ls_req_i = 1; settle();
      check_eq($sformatf("t4_addr%0d", i), mem_addr_o, 13'h020);
      check_eq($sformatf("t4_ls_gnt%0d", i), ls_gnt_o, 0);
    end
    next_cycle(); mem_gnt_i = 1; settle();
    check_eq("t4_if_gnt3", if_gnt_o, 1);
    next_cycle(); if_req_i = 0; settle();
    check_eq("t4_ls_gnt4", ls_gnt_o, 1);
    next_cycle(); idle_inputs(); mem_rvalid_i = 1; settle();
    check_eq("t4_rsp_if", if_rvalid_o, 1);
    next_cycle(); settle();
    check_eq("t4_rsp_ls", ls_rvalid_o, 1);
    next_cycle(); idle_inputs();

    // FIFO full at MAX_OUTST
    ls_req_i = 1; mem_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq($sformatf("t5_gnt%0d", i), ls_gnt_o, 1);
      next_cycle();
    end
    settle();
    check_eq("t5_full_req", mem_req_o, 0);
    check_eq("t5_full_gnt", ls_gnt_o, 0);
    next_cycle(); mem_rvalid_i = 1; settle();
    check_eq("t5_pop_req", mem_req_o, 0);
    check_eq("t5_pop_rvalid", ls_rvalid_o, 1);
    next_cycle(); settle();
    check_eq("t5_reopen_gnt", ls_gnt_o, 1);
    next_cycle(); mem_rvalid_i = 0; settle();
    check_eq("t5_refill_gnt", ls_gnt_o, 1);
    next_cycle(); settle();
    check_eq("t5_refull_req", mem_req_o, 0);
    idle_inputs(); mem_rvalid_i = 1;
    for (int i = 0; i < 4; i++) next_cycle();
    idle_inputs(); settle();
    check_eq("t5_err_clean", err_o, 0);
    next_cycle();

    // Stray response
    mem_rvalid_i = 1; settle();
    check_eq("t6_stray_if", if_rvalid_o, 0);
    check_eq("t6_stray_ls", ls_rvalid_o, 0);
    next_cycle(); idle_inputs(); settle();
    check_eq("t6_err_set", err_o, 1);
    next_cycle(); ls_req_i = 1; mem_gnt_i = 1; settle();
    check_eq("t6_err_sticky", err_o, 1);
    next_cycle(); idle_inputs();
    // Reset with one transaction outstanding
    ls_req_i = 1; mem_gnt_i = 1; rst_ni = 0; settle();
    check_eq("t6_rst_err", err_o, 0);
    check_eq("t6_rst_req", mem_req_o, 0);
    check_eq("t6_rst_gnt", ls_gnt_o, 0);
    next_cycle(); idle_inputs(); rst_ni = 1;
    next_cycle(); mem_rvalid_i = 1; settle();
    check_eq("t6_post_rst_rvalid", ls_rvalid_o, 0);
    next_cycle(); idle_inputs(); settle();
    check_eq("t6_post_rst_err", err_o, 1);
    rst_ni = 0;
    next_cycle(); rst_ni = 1;
    next_cycle();

    // Locked requester drops its request
    if_req_i = 1; settle();
    check_eq("t7_req", mem_req_o, 1);
    check_eq("t7_err_pre", err_o, 0);
    next_cycle(); if_req_i = 0;
    next_cycle(); settle();
    check_eq("t7_err_drop", err_o, 1);
    next_cycle(); ls_req_i = 1; mem_gnt_i = 1; settle();
    check_eq("t7_unlocked_ls", ls_gnt_o, 1);
    next_cycle(); idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
